// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the ALU operation sequencer.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W_DFLT = 8;
  localparam int unsigned OP_W        = 3;

  localparam logic [OP_W-1:0] OP_FWD  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_MULT = 3'b100;
  localparam logic [OP_W-1:0] OP_SLL  = 3'b101;
  localparam logic [OP_W-1:0] OP_SRL  = 3'b110;
  localparam logic [OP_W-1:0] OP_ILL  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MULT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/alu_mult_iter.sv
// Iterative shift-add multiplier: one multiplier bit per step, keeps the low DATA_W product bits.
module alu_mult_iter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done_c,
  output logic [DATA_W-1:0] acc_nxt_c
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [CNT_W-1:0]  cnt_q;

  // Product bits above DATA_W are never needed, so the multiplicand simply shifts out.
  always_comb begin
    acc_nxt_c = acc_q;
    if (mplier_q[0]) acc_nxt_c = acc_q + mcand_q;
  end

  assign done_c = step && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      cnt_q    <= '0;
    end else if (step) begin
      acc_q    <= acc_nxt_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller in front of the 8-bit ALU: accepts one op per start handshake,
// sequences MULT and bit-serial shifts, and returns result with a one-cycle done pulse.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   aluop,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [OP_W-1:0]   sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  state_e state_q, state_d, target_c;

  logic [DATA_W-1:0]  d1_q, d2_q;
  logic [SHAMT_W-1:0] cnt_q;

  logic              accept_c;
  logic              amt_zero_c, amt_ovf_c;
  logic              mult_load_c, mult_step_c, mult_done_c;
  logic              shift_load_c, shift_step_c;
  logic              finish_c, err_set_c;
  logic [DATA_W-1:0] mult_acc_nxt_c;
  logic [DATA_W-1:0] exec_res_c, shift_nxt_c, res_c;

  assign accept_c   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign amt_zero_c = (data2 == '0);
  assign amt_ovf_c  = (data2 >= DATA_W'(DATA_W));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Zero and out-of-range shift amounts resolve in one cycle on the EXEC path.
  always_comb begin
    target_c = ST_EXEC;
    if (aluop == OP_MULT) begin
      target_c = ST_MULT;
    end else if ((aluop == OP_SLL || aluop == OP_SRL) && !amt_zero_c && !amt_ovf_c) begin
      target_c = ST_SHIFT;
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = target_c;
      ST_EXEC:  state_d = ST_DONE;
      ST_MULT:  if (mult_done_c) state_d = ST_DONE;
      ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = start ? target_c : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mult_load_c  = accept_c && (aluop == OP_MULT);
    mult_step_c  = (state_q == ST_MULT);
    shift_load_c = accept_c && (target_c == ST_SHIFT);
    shift_step_c = (state_q == ST_SHIFT);
    finish_c     = (state_d == ST_DONE) && (state_q != ST_DONE);
    err_set_c    = (state_q == ST_EXEC) && (sel == OP_ILL);

    exec_res_c = '0;
    unique case (sel)
      OP_FWD:         exec_res_c = d2_q;
      OP_ADD:         exec_res_c = d1_q + d2_q;
      OP_AND:         exec_res_c = d1_q & d2_q;
      OP_OR:          exec_res_c = d1_q | d2_q;
      OP_SLL, OP_SRL: exec_res_c = (d2_q == '0) ? d1_q : '0;
      default:        exec_res_c = '0;
    endcase

    shift_nxt_c = (sel == OP_SLL) ? (d1_q << 1) : (d1_q >> 1);

    res_c = exec_res_c;
    unique case (state_q)
      ST_MULT:  res_c = mult_acc_nxt_c;
      ST_SHIFT: res_c = shift_nxt_c;
      default:  res_c = exec_res_c;
    endcase
  end

  // d1_q doubles as the shift register while in SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      d1_q   <= '0;
      d2_q   <= '0;
      cnt_q  <= '0;
    end else begin
      busy <= (state_d == ST_EXEC) || (state_d == ST_MULT) || (state_d == ST_SHIFT);
      done <= (state_d == ST_DONE);
      if (accept_c) begin
        sel  <= aluop;
        d1_q <= data1;
        d2_q <= data2;
        err  <= 1'b0;
      end else if (shift_step_c) begin
        d1_q <= shift_nxt_c;
      end
      if (shift_load_c) begin
        cnt_q <= data2[SHAMT_W-1:0];
      end else if (shift_step_c) begin
        cnt_q <= cnt_q - SHAMT_W'(1);
      end
      if (finish_c)  result <= res_c;
      if (err_set_c) err    <= 1'b1;
    end
  end

  alu_mult_iter #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk       (clk),
    .rst_n     (reset),
    .load      (mult_load_c),
    .step      (mult_step_c),
    .a         (data1),
    .b         (data2),
    .done_c    (mult_done_c),
    .acc_nxt_c (mult_acc_nxt_c)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with hand-computed expected values.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] aluop;
  logic [7:0] data1, data2;
  logic [2:0] sel;
  logic       busy, done, err;
  logic [7:0] result;

  int checks   = 0;
  int failures = 0;

  alu_op_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluop  (aluop),
    .data1  (data1),
    .data2  (data2),
    .sel    (sel),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then count edges from the accept edge until done.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] exp_res,
                       input logic exp_err, input int exp_lat);
    int n;
    int busy_cyc;
    start = 1'b1; aluop = op; data1 = d1; data2 = d2;
    tick();
    start = 1'b0;
    check({tag, ".sel"}, 32'(sel), 32'(op));
    check({tag, ".busy_e0"}, 32'(busy), 32'd1);
    n = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && n < 30) begin
      tick();
      n++;
      if (busy) busy_cyc++;
    end
    check({tag, ".lat"}, 32'(n), 32'(exp_lat));
    check({tag, ".busy_cyc"}, 32'(busy_cyc), 32'(exp_lat));
    check({tag, ".result"}, 32'(result), 32'(exp_res));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    tick();
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; aluop = '0; data1 = '0; data2 = '0;
    #12;
    check("rst.sel", 32'(sel), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    #10 reset = 1'b1;
    tick();

    do_op("add",    3'b001, 8'h05, 8'h03, 8'h08, 1'b0, 1);
    do_op("mult1",  3'b100, 8'h0D, 8'h0B, 8'h8F, 1'b0, 8);
    do_op("mult2",  3'b100, 8'h10, 8'h10, 8'h00, 1'b0, 8);
    do_op("sll3",   3'b101, 8'h81, 8'h03, 8'h08, 1'b0, 3);
    do_op("srl0",   3'b110, 8'h81, 8'h00, 8'h81, 1'b0, 1);
    do_op("srl9",   3'b110, 8'h81, 8'h09, 8'h00, 1'b0, 1);
    do_op("srl7",   3'b110, 8'h81, 8'h07, 8'h01, 1'b0, 7);
    do_op("sll8",   3'b101, 8'hFF, 8'h08, 8'h00, 1'b0, 1);
    do_op("fwd",    3'b000, 8'h12, 8'hA5, 8'hA5, 1'b0, 1);
    do_op("and",    3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1);
    do_op("ill",    3'b111, 8'hFF, 8'h01, 8'h00, 1'b1, 1);
    do_op("or_clr", 3'b011, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1);

    // ADD offered during MULT cycle 2 must be dropped.
    start = 1'b1; aluop = 3'b100; data1 = 8'h0D; data2 = 8'h0B;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; aluop = 3'b001; data1 = 8'h05; data2 = 8'h03;
    tick();
    start = 1'b0;
    n = 2;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    check("coll.lat", 32'(n), 32'd8);
    check("coll.result", 32'(result), 32'h8F);
    check("coll.sel", 32'(sel), 32'b100);
    tick();
    check("coll.idle_busy", 32'(busy), 32'd0);

    // Start held through done: second op accepted on the done cycle.
    start = 1'b1; aluop = 3'b001; data1 = 8'h05; data2 = 8'h03;
    tick();
    aluop = 3'b011; data1 = 8'h0F; data2 = 8'hF0;
    tick();
    check("b2b.done1", 32'(done), 32'd1);
    check("b2b.busy1", 32'(busy), 32'd0);
    check("b2b.res1", 32'(result), 32'h08);
    tick();
    start = 1'b0;
    check("b2b.sel2", 32'(sel), 32'b011);
    check("b2b.busy2", 32'(busy), 32'd1);
    check("b2b.done_lo", 32'(done), 32'd0);
    tick();
    check("b2b.done2", 32'(done), 32'd1);
    check("b2b.res2", 32'(result), 32'hFF);
    tick();

    // Asynchronous reset mid-MULT aborts it without a done.
    start = 1'b1; aluop = 3'b100; data1 = 8'h0D; data2 = 8'h0B;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("arst.sel", 32'(sel), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.result", 32'(result), 32'd0);
    check("arst.err", 32'(err), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n++;
    end
    check("arst.no_done", 32'(n), 32'd0);
    #2 reset = 1'b1;
    tick();
    do_op("post_rst", 3'b001, 8'h20, 8'h22, 8'h42, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle operation controller placed in front of the 8-bit ALU.
- Accepts one ALU operation per START handshake, latches the operands, and drives the ALU select code.
- Single-cycle operations (forward/add/and/or) complete in one cycle.
- MULT runs as an 8-step shift-add sequence; logical shifts run one bit per cycle.
- Returns RESULT with a one-cycle DONE pulse to the control unit, and holds BUSY so the CPU stalls until completion.

Parameters:
- DATA_W, 8, operand/result width; MULT iteration count equals DATA_W.
- SHAMT_W, 3, low bits of DATA2 used as shift amount; DATA2 >= DATA_W gives result 0.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request strobe; sampled only when BUSY=0.
- ALUOP  input  3  operation code, same encoding as the ALU select.
- DATA1  input  DATA_W  operand 1; value to be shifted for SLL/SRL.
- DATA2  input  DATA_W  operand 2; shift amount for SLL/SRL.
- SEL  output  3  latched op, drives ALU mux select.
- BUSY  output  1  operation in flight; new START is ignored.
- DONE  output  1  one-cycle pulse, RESULT valid.
- RESULT  output  DATA_W  result; held stable from DONE until the next accept.
- ERR  output  1  set with DONE when the opcode is illegal (3'b111).

Behaviour:
- Opcodes:
  - 000 FWD → RESULT=DATA2
  - 001 ADD → DATA1+DATA2 (mod 256, carry discarded)
  - 010 AND
  - 011 OR
  - 100 MULT → low 8 bits of DATA1*DATA2, unsigned
  - 101 SLL → DATA1<<DATA2
  - 110 SRL → DATA1>>DATA2, logical, zero fill
  - 111 illegal
- Reset (RESET=0, asynchronous): state=IDLE, SEL=000, BUSY=0, DONE=0, RESULT=0, ERR=0, all internal registers 0.
- Reset while an operation is in flight aborts it; no DONE is generated.
- Accept: the edge E0 where START=1 and BUSY=0. At E0 the block latches ALUOP into SEL and latches DATA1/DATA2, then sets BUSY=1.
- START while BUSY=1 is ignored, with no queuing and no error.
- FSM states: IDLE, EXEC, MULT, SHIFT, DONE_ST.
  - IDLE→EXEC on accept for ops 000–011 and 111.
  - IDLE→MULT on accept for 100.
  - IDLE→SHIFT on accept for 101/110 with 0 < amount < 8.
  - Shift amount 0 or >= 8 goes to EXEC: result is DATA1 for amount 0, and 0 for amount >= 8.
- EXEC: result registered at E1. DONE=1 and BUSY=0 after E1, so latency is 1 cycle.
- MULT: accumulator and multiplier/multiplicand shift registers, one bit processed per edge E1..E8. DONE=1 and BUSY=0 after E8, so latency is exactly DATA_W cycles regardless of operand values.
- SHIFT: a down-counter is loaded with the amount n. One bit shifts per edge; DONE comes after En, so latency is n cycles (1..7).
- DONE_ST / DONE: DONE lasts exactly one cycle, then the block returns to IDLE.
  - A START sampled in the same cycle that DONE is high is accepted, because BUSY is already 0. This gives back-to-back operation with no bubble.
- ERR: for op 111, RESULT=0 and ERR=1 together with DONE. ERR clears at the next accept.
- SEL holds the latched op from E0 until the next accept; it does not change while BUSY.

Decomposition:
- Package alu_ctrl_pkg:
  - opcode localparams OP_FWD..OP_SRL, OP_ILL
  - FSM state encodings
  - DATA_W default
- Sub-module alu_mult_iter: 8-step shift-add multiplier with load/step/done interface, instantiated by the sequencer.
- Shift and single-cycle logic stay inline.

Test Plan:
- ADD 8'h05+8'h03 → SEL=001 after E0; RESULT=8'h08 with DONE high after E1; BUSY high exactly 1 cycle.
- MULT 8'h0D*8'h0B → RESULT=8'h8F with DONE after E8, BUSY high 8 cycles. Then MULT 8'h10*8'h10 → RESULT=8'h00 (overflow truncated).
- SLL 8'h81 by 3 → RESULT=8'h08 after E3. SRL 8'h81 by 0 → 8'h81 after E1. SRL 8'h81 by 9 → 8'h00 after E1.
- Busy collision: START an ADD at cycle 2 of a MULT → ignored; original MULT result and timing unchanged. Back-to-back: START held through DONE → second op accepted at the DONE cycle.
- Illegal op 111 with DATA1=8'hFF → RESULT=8'h00, ERR=1, DONE after E1; next legal op clears ERR.
- RESET driven low asynchronously at cycle 4 of a MULT → all outputs 0 immediately, no DONE. The next START after release completes normally.
